// File: rtl/cartesian_to_polar_pkg.sv
// Shared constants for the polar/Cartesian conversion paths: bin count, widths,
// Q8 trig tables, FSM encoding and the radius saturation helper.
package cartesian_to_polar_pkg;

  localparam int ANGLE_BINS = 12;
  localparam int ANGLE_W    = 4;
  localparam int RADIUS_W   = 8;
  localparam int COORD_W    = 9;
  localparam int COEF_W     = 10;
  localparam int PROJ_W     = 20;

  localparam logic signed [PROJ_W-1:0] PROJ_MIN = {1'b1, {(PROJ_W-1){1'b0}}};

  // 15-degree bins, 0..165 degrees, scaled by 256
  localparam logic signed [COEF_W-1:0] COS_Q8 [ANGLE_BINS] = '{
    10'sd256, 10'sd247, 10'sd222, 10'sd181, 10'sd128, 10'sd66,
    10'sd0,  -10'sd66, -10'sd128, -10'sd181, -10'sd222, -10'sd247
  };
  localparam logic signed [COEF_W-1:0] SIN_Q8 [ANGLE_BINS] = '{
    10'sd0,   10'sd66,  10'sd128, 10'sd181, 10'sd222, 10'sd247,
    10'sd256, 10'sd247, 10'sd222, 10'sd181, 10'sd128, 10'sd66
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Drop the Q8 fraction and clamp to the unsigned radius range.
  function automatic logic [RADIUS_W-1:0] sat_radius(input logic signed [PROJ_W-1:0] p);
    logic signed [PROJ_W-1:0] s;
    s = p >>> 8;
    if (s[PROJ_W-1])
      sat_radius = '0;
    else if (|s[PROJ_W-2:RADIUS_W])
      sat_radius = '1;
    else
      sat_radius = s[RADIUS_W-1:0];
  endfunction

endpackage

// File: rtl/cartesian_to_polar_if.sv
// Start/done request bundle for the Cartesian-to-polar converter.
interface cartesian_to_polar_if;
  import cartesian_to_polar_pkg::*;

  logic                              start;
  logic signed [COORD_W-1:0]         x_value;
  logic signed [COORD_W-1:0]         y_value;
  logic                              busy;
  logic                              done;
  logic [ANGLE_W+RADIUS_W-1:0]       r_theta;
  logic                              y_clamped;

  modport master (
    output start, x_value, y_value,
    input  busy, done, r_theta, y_clamped
  );

  modport slave (
    input  start, x_value, y_value,
    output busy, done, r_theta, y_clamped
  );
endinterface

// File: rtl/cartesian_to_polar_trig_rom.sv
// Combinational bin index -> {cos, sin} lookup from the shared Q8 tables.
module trig_rom
  import cartesian_to_polar_pkg::*;
(
  input  logic [ANGLE_W-1:0]        i_k,
  output logic signed [COEF_W-1:0]  o_cos,
  output logic signed [COEF_W-1:0]  o_sin
);

  always_comb begin
    o_cos = '0;
    o_sin = '0;
    if (i_k < ANGLE_W'(ANGLE_BINS)) begin
      o_cos = COS_Q8[i_k];
      o_sin = SIN_Q8[i_k];
    end
  end

endmodule

// File: rtl/cartesian_to_polar.sv
// Upper-half-plane (x, y) -> {angle bin, radius}: scans one 15-degree bin per
// clock and keeps the bin with the largest projection x*cos + y*sin.
module cartesian_to_polar
  import cartesian_to_polar_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  cartesian_to_polar_if.slave  bus
);

  state_e                     r_state, w_state_nxt;
  logic [ANGLE_W-1:0]         r_k;
  logic [ANGLE_W-1:0]         r_best_k;
  logic signed [PROJ_W-1:0]   r_best_p;
  logic signed [COORD_W-1:0]  r_x;
  logic signed [COORD_W-1:0]  r_y_eff;
  logic                       r_y_neg;
  logic                       r_busy;
  logic                       r_done;
  logic [ANGLE_W+RADIUS_W-1:0] r_theta_q;
  logic                       r_y_clamped;

  logic signed [COEF_W-1:0]   w_cos, w_sin;
  logic signed [PROJ_W-1:0]   w_xc, w_ys, w_p;
  logic                       w_last_bin;

  trig_rom u_trig_rom (
    .i_k   (r_k),
    .o_cos (w_cos),
    .o_sin (w_sin)
  );

  // Operands are sign-extended to the projection width before the multiply.
  assign w_xc       = PROJ_W'(r_x) * PROJ_W'(w_cos);
  assign w_ys       = PROJ_W'(r_y_eff) * PROJ_W'(w_sin);
  assign w_p        = w_xc + w_ys;
  assign w_last_bin = (r_k == ANGLE_W'(ANGLE_BINS - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_last_bin) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_k         <= '0;
      r_best_k    <= '0;
      r_best_p    <= '0;
      r_x         <= '0;
      r_y_eff     <= '0;
      r_y_neg     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_theta_q   <= '0;
      r_y_clamped <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_x      <= bus.x_value;
            r_y_neg  <= bus.y_value[COORD_W-1];
            r_y_eff  <= bus.y_value[COORD_W-1] ? '0 : bus.y_value;
            r_k      <= '0;
            r_best_k <= '0;
            r_best_p <= PROJ_MIN;
            r_busy   <= 1'b1;
          end
        end
        ST_SCAN: begin
          // Strict compare so the lowest bin keeps a tie.
          if (w_p > r_best_p) begin
            r_best_p <= w_p;
            r_best_k <= r_k;
          end
          r_k <= r_k + 1'b1;
        end
        ST_DONE: begin
          r_theta_q   <= {r_best_k, sat_radius(r_best_p)};
          r_y_clamped <= r_y_neg;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.r_theta   = r_theta_q;
  assign bus.y_clamped = r_y_clamped;

endmodule

// File: tb/tb_cartesian_to_polar.sv
// Directed table, corner sequences and randomized checks against a max-projection model.
module tb_cartesian_to_polar;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cartesian_to_polar_if bus();

  cartesian_to_polar dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    int         x;
    int         y;
    logic [11:0] rt;
    logic        yc;
  } vec_t;

  vec_t tv[7];

  int cos_t[12] = '{256, 247, 222, 181, 128, 66, 0, -66, -128, -181, -222, -247};
  int sin_t[12] = '{0, 66, 128, 181, 222, 247, 256, 247, 222, 181, 128, 66};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pick the 15-degree bin with the largest projection, lowest bin on ties.
  task automatic model(input int x, input int y, output logic [11:0] rt, output logic yc);
    int ye, best, bk, p, r;
    ye = (y < 0) ? 0 : y;
    best = -(1 << 30);
    bk = 0;
    for (int k = 0; k < 12; k++) begin
      p = x * cos_t[k] + ye * sin_t[k];
      if (p > best) begin best = p; bk = k; end
    end
    r = best >>> 8;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    rt = {bk[3:0], r[7:0]};
    yc = (y < 0);
  endtask

  // Start pulse, then count edges until done; returns latency (-1 on timeout).
  task automatic convert(input int x, input int y, output logic [11:0] rt,
                         output logic yc, output int lat);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.x_value = 9'(x);
    bus.y_value = 9'(y);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) lat = -1;
    rt = bus.r_theta;
    yc = bus.y_clamped;
  endtask

  initial begin
    logic [11:0] rt, ert;
    logic        yc, eyc;
    int          lat, cnt, seen;
    logic signed [8:0] rx, ry;

    tv[0] = '{x: 100,  y: 0,   rt: 12'h064, yc: 1'b0};
    tv[1] = '{x: 97,   y: 26,  rt: 12'h164, yc: 1'b0};
    tv[2] = '{x: -97,  y: 26,  rt: 12'hB64, yc: 1'b0};
    tv[3] = '{x: 0,    y: 100, rt: 12'h664, yc: 1'b0};
    tv[4] = '{x: 0,    y: 0,   rt: 12'h000, yc: 1'b0};
    tv[5] = '{x: 255,  y: 255, rt: 12'h3FF, yc: 1'b0};
    tv[6] = '{x: 50,   y: -10, rt: 12'h032, yc: 1'b1};

    bus.start = 1'b0;
    bus.x_value = '0;
    bus.y_value = '0;
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_rtheta", 32'(bus.r_theta), 32'h000);
    chk("reset_yclamp", 32'(bus.y_clamped), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      convert(tv[i].x, tv[i].y, rt, yc, lat);
      chk($sformatf("tbl%0d_rtheta", i), 32'(rt), 32'(tv[i].rt));
      chk($sformatf("tbl%0d_yclamp", i), 32'(yc), 32'(tv[i].yc));
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd13);
      chk($sformatf("tbl%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
    end

    // Accepted start raises busy; a second start mid-scan is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.x_value = 9'sd100; bus.y_value = 9'sd0;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.x_value = 9'sd0; bus.y_value = 9'sd100;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 5;
    while (!bus.done && cnt < 40) begin @(posedge clk); #1; cnt++; end
    chk("ignore_latency", 32'(cnt), 32'd13);
    chk("ignore_rtheta", 32'(bus.r_theta), 32'h064);
    repeat (20) @(posedge clk);
    #1;
    chk("ignore_no_second_done", 32'(bus.done), 32'd0);

    // Back-to-back with start held high: dones 14 cycles apart
    @(negedge clk);
    bus.start = 1'b1; bus.x_value = 9'sd0; bus.y_value = 9'sd100;
    @(posedge clk); #1;
    cnt = 0; seen = 0;
    while (seen < 2 && cnt < 60) begin
      @(posedge clk); #1; cnt++;
      if (bus.done) begin
        seen++;
        chk($sformatf("b2b_done%0d_cycle", seen), 32'(cnt), (seen == 1) ? 32'd13 : 32'd27);
        chk($sformatf("b2b_done%0d_rtheta", seen), 32'(bus.r_theta), 32'h664);
      end
    end
    chk("b2b_two_dones", 32'(seen), 32'd2);
    bus.start = 1'b0;
    repeat (20) @(posedge clk);

    // Reset mid-scan aborts without done
    @(negedge clk);
    bus.start = 1'b1; bus.x_value = 9'sd100; bus.y_value = 9'sd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rtheta", 32'(bus.r_theta), 32'h000);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 16; i++) begin @(posedge clk); #1; if (bus.done) seen++; end
    chk("abort_no_done", 32'(seen), 32'd0);
    convert(0, 100, rt, yc, lat);
    chk("after_abort_rtheta", 32'(rt), 32'h664);
    chk("after_abort_latency", 32'(lat), 32'd13);

    // Randomized against the model, results also held until next done
    for (int i = 0; i < 40; i++) begin
      rx = 9'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 255));
      model(int'(rx), int'(ry), ert, eyc);
      convert(int'(rx), int'(ry), rt, yc, lat);
      chk($sformatf("rnd%0d_rtheta x=%0d y=%0d", i, rx, ry), 32'(rt), 32'(ert));
      chk($sformatf("rnd%0d_yclamp", i), 32'(yc), 32'(eyc));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd13);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_hold", i), 32'(bus.r_theta), 32'(ert));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cartesian_to_polar.md
# cartesian_to_polar

Converts a signed Cartesian point (x, y) in the upper half-plane into the packed polar word used across the design: a 4-bit angle index (15° bins, 0°–165°) and an 8-bit radius. It is the inverse of the shared polar-to-Cartesian path. It is used wherever a located object must be re-expressed as an angle/radius pair, for example to command the mount. It is a multi-cycle, start/done block that scans the 12 angle bins, one bin per clock.

## Interface
Parameters:
- none. All constants live in the shared package.

Ports:
- clock  in  1  system clock; all state is updated on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request conversion; sampled only in IDLE
- x_value  in  9  signed two's-complement x, range -256..255
- y_value  in  9  signed two's-complement y; valid range is 0..255
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; r_theta is valid from this cycle onward
- r_theta  out  12  [11:8] angle index k (angle = 15·k°), [7:0] radius
- y_clamped  out  1  latched with r_theta; 1 if the input y was negative

## Operation
- States: IDLE, SCAN, DONE.
- IDLE, start=1:
  - Latch x and y_eff, where y_eff = (y<0) ? 0 : y.
  - Latch y_clamped.
  - Set k=0, best_p to the most negative value, best_k=0. Go to SCAN.
- SCAN, one bin per cycle:
  - p_k = x·COS[k] + y_eff·SIN[k]. COS and SIN are Q8 signed 10-bit; p_k is 20-bit signed.
  - If p_k > best_p (strictly greater), then best_p=p_k and best_k=k. On a tie the lowest k wins.
  - After k=11, go to DONE.
- DONE:
  - r_theta = {best_k, sat(best_p>>>8)}, where sat clamps to 0..255 (a negative value gives 0).
  - Pulse done and return to IDLE.
- Q8 constants:
  - COS = 256, 247, 222, 181, 128, 66, 0, -66, -128, -181, -222, -247
  - SIN = 0, 66, 128, 181, 222, 247, 256, 247, 222, 181, 128, 66
- start is ignored while busy. No queueing.
- Inputs are captured at acceptance, so later input changes do not affect the result.
- Radius is the projection onto the nearest bin. Its error is at most 1-cos(7.5°) ≈ 0.9% plus truncation.

## Timing
- Reset (async assert, synchronous deassert expected upstream):
  - state=IDLE
  - busy=0, done=0, r_theta=12'h000, y_clamped=0
  - internal registers cleared
- Start accepted at edge N:
  - busy=1 from N.
  - SCAN covers k=0..11 on edges N+1..N+12.
  - done=1 and r_theta updated at edge N+13; busy=0 in the same cycle.
  - Total latency from acceptance to done is 13 cycles.
- start held high continuously gives back-to-back conversions: the next is accepted on the edge after DONE (N+14).
- r_theta and y_clamped hold their values until the next DONE.
- Reset asserted mid-SCAN: everything returns to reset values immediately, no done pulse is produced, and the partial result is discarded.

## Structure
- Shared package holds:
  - ANGLE_BINS=12
  - ANGLE_W=4, RADIUS_W=8, COORD_W=9, COEF_W=10
  - COS_Q8/SIN_Q8 tables
  - state encoding
- Sub-module trig_rom: combinational k → {cos, sin} lookup from the package tables. It is shared with any future user of the tables.
- Datapath is a single multiply-accumulate pair, one per cycle. No parallel 12-way compute.

## Test plan
- (100,0), start pulse → done at +13 cycles, r_theta=12'h0_64, y_clamped=0.
- (97,26) → 12'h1_64; (-97,26) → 12'hB_64 (p=25675, radius 100).
- (0,100) → 12'h6_64; (0,0) → 12'h000 (tie, lowest k wins).
- (255,255) → 12'h3_FF (p=92310, saturated); (50,-10) → 12'h0_32, y_clamped=1.
- start pulsed again at +5 cycles with different inputs → ignored, original result returned.
- Reset mid-SCAN, then start with (0,100) → no done from the aborted run, then 12'h6_64.
